// File: rtl/img_pkg.sv
// Shared definitions for the processed-frame read path.
// Contents:
//   DEF_IMG_W / DEF_IMG_H - default frame geometry in pixels
//   DEF_FRAME_PIXELS      - default number of pixels in one frame
//   stream_state_e        - streamer FSM states (IDLE, RUN, FLUSH)
//   pix_marker_t          - per-pixel frame markers {sof, eol, eof}
package img_pkg;

  localparam int DEF_IMG_W        = 64;
  localparam int DEF_IMG_H        = 64;
  localparam int DEF_FRAME_PIXELS = DEF_IMG_W * DEF_IMG_H;
  localparam int MARK_W           = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } stream_state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_marker_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid FIFO that sits between the buffer read port and the
// pixel stream. The head entry is the presented output word and only changes
// when it is consumed or when the FIFO is empty, so the output is held steady
// under backpressure.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   in_valid   - write strobe (the writer keeps occupancy within two)
//   in_data    - word to write
//   out_valid  - head entry is valid
//   out_ready  - consumer accepts the head entry
//   out_data   - head entry
//   count      - current occupancy (0..2)
module stream_skid_fifo #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign pop       = (count_q != 2'd0) && out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

  // Head/tail shuffle. A write into a full FIFO without a pop is dropped;
  // the writer's issue rule never lets that happen.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({in_valid, pop})
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = in_data;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_output_streamer.sv
// Read side of the processed-frame buffer. On a start pulse it reads
// IMG_W x IMG_H pixels in raster order from a 1-cycle-latency buffer RAM and
// emits them as a valid/ready stream with sof/eol/eof markers.
// Optional build macro: OUT_BINARIZE_EN - output pixels become all-ones when
// the buffer value is >= THRESH, else all-zeros (timing unchanged).
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   start           - one-cycle pulse, frame ready in buffer (ignored if busy)
//   busy            - frame in progress
//   done            - one-cycle pulse after the last pixel handshake
//   mem_rd_en       - buffer read strobe
//   mem_addr        - buffer read address (row*IMG_W + col)
//   mem_rd_data     - buffer data, valid one cycle after mem_rd_en
//   m_pixel/m_valid/m_ready - output pixel stream
//   m_sof/m_eol/m_eof       - frame markers qualifying m_pixel
import img_pkg::*;

module frame_output_streamer #(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 12,
  parameter int THRESH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  m_pixel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FIFO_W = PIX_W + MARK_W;
  localparam logic [PIX_W-1:0] THRESH_PIX = THRESH[PIX_W-1:0];

  stream_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              inflight_q;
  pix_marker_t       inflightMark_q;
  pix_marker_t       issueMark;
  pix_marker_t       headMark;
  logic              done_q;
  logic              rdEn;
  logic              colLast, rowLast;
  logic [PIX_W-1:0]  pixIn;
  logic [FIFO_W-1:0] fifoIn, fifoOut;
  logic              fifoValid;
  logic [1:0]        fifoCount;
  logic              handshake, eofAccept;
  logic [2:0]        effOcc;

`ifdef OUT_BINARIZE_EN
  assign pixIn = (mem_rd_data >= THRESH_PIX) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
  logic unusedThresh;
  assign unusedThresh = ^THRESH_PIX;
  assign pixIn        = mem_rd_data;
`endif

  assign colLast   = (col_q == COL_W'(IMG_W - 1));
  assign rowLast   = (row_q == ROW_W'(IMG_H - 1));
  assign handshake = fifoValid && m_ready;
  assign headMark  = pix_marker_t'(fifoOut[FIFO_W-1:PIX_W]);
  assign eofAccept = handshake && headMark.eof;

  // Occupancy net of the pixel leaving this cycle, plus the read still in
  // flight. Issuing only while this is below two means a read issued now
  // always finds a free slot when its data lands, even if the consumer
  // stalls, yet a free-flowing stream still sustains one read per cycle.
  assign effOcc = {1'b0, fifoCount} + {2'b00, inflight_q} - {2'b00, handshake};

  // Next-state logic: raster address/col/row counters and frame FSM.
  // Counters stop on the last pixel and are cleared by the next start.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    col_d         = col_q;
    row_d         = row_q;
    rdEn          = 1'b0;
    issueMark.sof = (col_q == '0) && (row_q == '0);
    issueMark.eol = colLast;
    issueMark.eof = colLast && rowLast;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        rdEn = (effOcc < 3'd2);
        if (rdEn) begin
          if (colLast && rowLast) begin
            state_d = FLUSH;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (colLast) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      FLUSH: begin
        if (eofAccept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Markers travel alongside the outstanding read so they meet its data at
  // the FIFO write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      col_q          <= '0;
      row_q          <= '0;
      inflight_q     <= 1'b0;
      inflightMark_q <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      col_q          <= col_d;
      row_q          <= row_d;
      inflight_q     <= rdEn;
      inflightMark_q <= issueMark;
      done_q         <= eofAccept;
    end
  end

  assign fifoIn = {inflightMark_q, pixIn};

  stream_skid_fifo #(
    .W(FIFO_W)
  ) uSkid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inflight_q),
    .in_data  (fifoIn),
    .out_valid(fifoValid),
    .out_ready(m_ready),
    .out_data (fifoOut),
    .count    (fifoCount)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign mem_rd_en = rdEn;
  assign mem_addr  = addr_q;
  assign m_valid   = fifoValid;
  assign m_pixel   = fifoOut[PIX_W-1:0];
  assign m_sof     = headMark.sof;
  assign m_eol     = headMark.eol;
  assign m_eof     = headMark.eof;

endmodule

// File: tb/tb_frame_output_streamer.sv
// Self-checking bench for frame_output_streamer. A buffer RAM model feeds the
// DUT; a frame-level model (expected pixel queue built from buffer contents)
// is compared against the stream every cycle, with literal checks on latency,
// stalls, aborts and binarization. Honours OUT_BINARIZE_EN if defined.
module tb_frame_output_streamer;

  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 12;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rd_data;
  logic [PIX_W-1:0]  m_pixel;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  logic [PIX_W-1:0] mem [NPIX];

  typedef struct {
    logic [PIX_W-1:0] pix;
    logic             sof;
    logic             eol;
    logic             eof;
  } exp_t;

  exp_t expQ[$];
  exp_t e;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;
  int frameHs     = 0;
  int issuedCnt   = 0;
  int acceptedCnt = 0;
  int doneCnt     = 0;
  int eolCnt      = 0;
  int firstHsCycle = 0;
  int eofHsCycle  = 0;
  int readyMode   = 0;
  int stallLeft   = 0;
  logic [PIX_W-1:0] firstPix [2];
  logic             doneDue   = 1'b0;
  logic             prevStall = 1'b0;
  logic [PIX_W+2:0] held      = '0;

  always #5 clk = ~clk;

  frame_output_streamer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W),
    .THRESH(128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .m_pixel    (m_pixel),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_eof      (m_eof)
  );

  // Buffer RAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  function automatic logic [PIX_W-1:0] expPix(input logic [PIX_W-1:0] v);
`ifdef OUT_BINARIZE_EN
    return (v >= 8'd128) ? 8'hFF : 8'h00;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Pulse start; when newFrame is set, first load the model with the frame
  // the buffer currently holds.
  task automatic applyStimulus(input bit newFrame);
    if (newFrame) begin
      for (int a = 0; a < NPIX; a++)
        expQ.push_back('{pix: expPix(mem[a]), sof: (a == 0),
                         eol: ((a % IMG_W) == IMG_W - 1), eof: (a == NPIX - 1)});
      frameHs = 0;
      eolCnt  = 0;
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int base;
    int n;
    base = doneCnt;
    n    = 0;
    while (doneCnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_done_seen", doneCnt != base, 1);
    repeat (3) @(negedge clk);
    checkOutput("single_done", doneCnt - base, 1);
    checkOutput("frame_pixels", frameHs, NPIX);
    checkOutput("exp_queue_empty", expQ.size(), 0);
  endtask

  // Downstream ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: m_ready = 1'($urandom_range(0, 1));
        2: begin
          if (frameHs == 100 && stallLeft > 0) begin
            m_ready = 1'b0;
            stallLeft--;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Per-cycle compare against the frame model
  always @(negedge clk) begin
    cycleCnt++;
    if (rst) begin
      expQ.delete();
      issuedCnt   = 0;
      acceptedCnt = 0;
      doneDue     = 1'b0;
      prevStall   = 1'b0;
    end else begin
      checkOutput("done_pulse", done, doneDue);
      if (doneDue) checkOutput("busy_in_done_cycle", busy, 0);
      if (done) doneCnt++;
      if (prevStall) begin
        checkOutput("valid_held", m_valid, 1);
        checkOutput("data_held", {m_pixel, m_sof, m_eol, m_eof}, held);
      end
      if (mem_rd_en) begin
        checkOutput("rd_addr_order", mem_addr, issuedCnt % NPIX);
        issuedCnt++;
      end
      doneDue = 1'b0;
      if (m_valid && m_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pixel", expQ.size(), 1);
        end else begin
          e = expQ.pop_front();
          checkOutput("pixel", m_pixel, e.pix);
          checkOutput("sof", m_sof, e.sof);
          checkOutput("eol", m_eol, e.eol);
          checkOutput("eof", m_eof, e.eof);
          doneDue = e.eof;
        end
        if (frameHs < 2) firstPix[frameHs] = m_pixel;
        if (frameHs == 0) firstHsCycle = cycleCnt;
        if (m_eol) eolCnt++;
        if (m_eof) eofHsCycle = cycleCnt;
        frameHs++;
        acceptedCnt++;
      end
      checkOutput("outstanding_le_2", (issuedCnt - acceptedCnt) <= 2, 1);
      prevStall = m_valid && !m_ready;
      held      = {m_pixel, m_sof, m_eol, m_eof};
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    for (int a = 0; a < NPIX; a++) mem[a] = 8'(a % 256);
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", m_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rd_en", mem_rd_en, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_done", done, 0);
    rst = 1'b0;

    $display("[TB] frame 1: ramp, ready held high");
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("lat_rd_en_e0", mem_rd_en, 1);
    checkOutput("lat_addr_e0", mem_addr, 0);
    checkOutput("lat_busy_e0", busy, 1);
    checkOutput("lat_valid_e0", m_valid, 0);
    @(negedge clk);
    checkOutput("lat_valid_e1", m_valid, 0);
    checkOutput("lat_addr_e1", mem_addr, 1);
    @(negedge clk);
    checkOutput("lat_valid_e2", m_valid, 1);
    checkOutput("lat_pixel_e2", m_pixel, 0);
    checkOutput("lat_sof_e2", m_sof, 1);
    waitDone(6000);
    checkOutput("eol_count", eolCnt, 64);
    checkOutput("frame_span", eofHsCycle - firstHsCycle, NPIX - 1);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] frame 2: random ready");
    readyMode = 1;
    applyStimulus(1'b1);
    waitDone(40000);
    readyMode = 0;

    $display("[TB] frame 3: 20-cycle stall at pixel 100");
    stallLeft = 20;
    readyMode = 2;
    applyStimulus(1'b1);
    n = 0;
    while (stallLeft != 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_reached", stallLeft, 10);
    checkOutput("stall_valid", m_valid, 1);
`ifdef OUT_BINARIZE_EN
    checkOutput("stall_pixel", m_pixel, 8'h00);
`else
    checkOutput("stall_pixel", m_pixel, 100);
`endif
    checkOutput("stall_rd_en", mem_rd_en, 0);
    waitDone(8000);
    readyMode = 0;

    $display("[TB] frame 4: start pulsed mid-frame");
    applyStimulus(1'b1);
    n = 0;
    while (frameHs < 500 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(1'b0);
    waitDone(8000);

    $display("[TB] frame 5: reset mid-frame");
    applyStimulus(1'b1);
    n = 0;
    while (frameHs < 2000 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_valid", m_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rd_en", mem_rd_en, 0);
    checkOutput("abort_addr", mem_addr, 0);
    checkOutput("abort_markers", {m_sof, m_eol, m_eof}, 0);
    checkOutput("abort_pixel", m_pixel, 0);
    checkOutput("abort_done", done, 0);
    base = doneCnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("no_done_after_abort", doneCnt, base);
    applyStimulus(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("restart_sof", m_sof, 1);
    checkOutput("restart_pixel", m_pixel, 0);
    waitDone(6000);

    $display("[TB] frame 6: threshold boundary values");
    mem[0] = 8'h7F;
    mem[1] = 8'h80;
    applyStimulus(1'b1);
    waitDone(6000);
`ifdef OUT_BINARIZE_EN
    checkOutput("bin_7f", firstPix[0], 8'h00);
    checkOutput("bin_80", firstPix[1], 8'hFF);
`else
    checkOutput("raw_7f", firstPix[0], 8'h7F);
    checkOutput("raw_80", firstPix[1], 8'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
